// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters advanced by a pixel-rate
// clock enable, with registered sync, active-video, coordinates and start pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_nxt;
  logic             vs_nxt;
  logic             act_nxt;

  // Next raster position; all outputs are decoded from it so they line up with x/y.
  always_comb begin
    h_wrap = (h == H_LAST);
    v_wrap = (v == V_LAST);
    h_nxt  = h_wrap ? '0 : h + 1'b1;
    v_nxt  = v;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : v + 1'b1;
    end
    act_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    hs_nxt  = ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vs_nxt  = ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
  end

  // Counters preload to the last position so the first enabled tick lands on (0,0)
  // and produces the frame_start pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h           <= H_LAST;
      v           <= V_LAST;
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce && h_wrap;
      frame_start <= pix_ce && h_wrap && v_wrap;
      if (pix_ce) begin
        h      <= h_nxt;
        v      <= v_nxt;
        x      <= h_nxt;
        y      <= v_nxt;
        active <= act_nxt;
        hsync  <= hs_nxt;
        vsync  <= vs_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a reduced-geometry instance pair (both sync
// polarities) for frame-level checks and a default-geometry instance for line checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b0;

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reduced geometry: H 8+2+3+3 = 16, hsync at x 10..12; V 6+1+2+2 = 11, vsync at y 7..8.
  logic       s_hsync, s_vsync, s_active, s_ls, s_fs;
  logic [4:0] s_x, s_y;
  logic       p_hsync, p_vsync, p_active, p_ls, p_fs;
  logic [4:0] p_x, p_y;
  logic       d_hsync, d_vsync, d_active, d_ls, d_fs;
  logic [9:0] d_x, d_y;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .CNT_W(5)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(s_hsync), .vsync(s_vsync), .active(s_active),
    .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .CNT_W(5)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(p_hsync), .vsync(p_vsync), .active(p_active),
    .x(p_x), .y(p_y), .line_start(p_ls), .frame_start(p_fs)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(d_hsync), .vsync(d_vsync), .active(d_active),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  // Driver: hold reset two edges, then release with pix_ce high.
  task automatic do_reset();
    rst_n  = 1'b0;
    pix_ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    pix_ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if ({s_x, s_y, s_active, s_hsync, s_vsync, s_ls, s_fs} !== {5'd0, 5'd0, 5'b01100}) begin
        tests_failed++;
        $display("FAIL reset_small: x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b, required 0 0 0 1 1 0 0",
                 s_x, s_y, s_active, s_hsync, s_vsync, s_ls, s_fs);
      end
      tests_run++;
      if ({d_x, d_y, d_active, d_hsync, d_vsync, d_ls, d_fs} !== {10'd0, 10'd0, 5'b01100}) begin
        tests_failed++;
        $display("FAIL reset_default: x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b, required 0 0 0 1 1 0 0",
                 d_x, d_y, d_active, d_hsync, d_vsync, d_ls, d_fs);
      end
      tests_run++;
      if ({p_hsync, p_vsync, p_active, p_ls, p_fs} !== 5'b00000) begin
        tests_failed++;
        $display("FAIL reset_pol: hs=%b vs=%b act=%b ls=%b fs=%b, required 0 0 0 0 0",
                 p_hsync, p_vsync, p_active, p_ls, p_fs);
      end
    end
  endtask

  task automatic test_first_tick();
    rst_n  = 1'b1;
    pix_ce = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({s_x, s_y, s_active, s_ls, s_fs} !== {5'd0, 5'd0, 3'b111}) begin
      tests_failed++;
      $display("FAIL first_tick_small: x=%0d y=%0d act=%b ls=%b fs=%b, required 0 0 1 1 1",
               s_x, s_y, s_active, s_ls, s_fs);
    end
    tests_run++;
    if ({d_x, d_y, d_active, d_ls, d_fs, d_hsync, d_vsync} !== {10'd0, 10'd0, 5'b11111}) begin
      tests_failed++;
      $display("FAIL first_tick_default: x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b, required 0 0 1 1 1 1 1",
               d_x, d_y, d_active, d_ls, d_fs, d_hsync, d_vsync);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({d_x, d_y, d_ls, d_fs} !== {10'd1, 10'd0, 2'b00}) begin
      tests_failed++;
      $display("FAIL second_tick_default: x=%0d y=%0d ls=%b fs=%b, required 1 0 0 0",
               d_x, d_y, d_ls, d_fs);
    end
  endtask

  // Full 800-pixel line on the default geometry.
  task automatic test_line_timing();
    int bad;
    int first_bad;
    int hs_low;
    logic exp_act;
    logic exp_hs;
    bad = 0;
    first_bad = -1;
    hs_low = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      exp_act = (i < 640);
      exp_hs  = !((i >= 656) && (i <= 751));
      if (d_hsync === 1'b0) hs_low++;
      if ((d_x !== 10'(i)) || (d_y !== 10'd0) || (d_active !== exp_act) || (d_hsync !== exp_hs) ||
          (d_ls !== (i == 0)) || (d_fs !== (i == 0))) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL line_decode: %0d bad cycles (first at x=%0d), required 0", bad, first_bad);
    end
    tests_run++;
    if (hs_low !== 96) begin
      tests_failed++;
      $display("FAIL hsync_width: low for %0d clk, required 96", hs_low);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({d_x, d_y, d_ls, d_fs, d_active} !== {10'd0, 10'd1, 3'b101}) begin
      tests_failed++;
      $display("FAIL line_wrap: x=%0d y=%0d ls=%b fs=%b act=%b, required 0 1 1 0 1",
               d_x, d_y, d_ls, d_fs, d_active);
    end
  endtask

  // Two full frames on the reduced geometry, both polarities compared.
  task automatic test_frame_timing();
    int bad;
    int first_bad;
    int pol_bad;
    int vs_low;
    int fs_cnt;
    int last_fs;
    int gap_bad;
    int ex, ey;
    logic exp_act, exp_hs, exp_vs;
    bad = 0; first_bad = -1; pol_bad = 0; vs_low = 0;
    fs_cnt = 0; last_fs = -1; gap_bad = 0;
    do_reset();
    for (int i = 0; i <= 352; i++) begin
      @(posedge clk);
      #1;
      ex = i % 16;
      ey = (i / 16) % 11;
      exp_act = (ex < 8) && (ey < 6);
      exp_hs  = !((ex >= 10) && (ex <= 12));
      exp_vs  = !((ey >= 7) && (ey <= 8));
      if ((i < 176) && (s_vsync === 1'b0)) vs_low++;
      if ((s_x !== 5'(ex)) || (s_y !== 5'(ey)) || (s_active !== exp_act) || (s_hsync !== exp_hs) ||
          (s_vsync !== exp_vs) || (s_ls !== (ex == 0)) || (s_fs !== ((ex == 0) && (ey == 0)))) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if ((p_hsync !== !exp_hs) || (p_vsync !== !exp_vs)) pol_bad++;
      if (s_fs === 1'b1) begin
        if ((last_fs >= 0) && (i - last_fs != 176)) gap_bad++;
        last_fs = i;
        fs_cnt++;
      end
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL frame_decode: %0d bad cycles (first at cycle %0d), required 0", bad, first_bad);
    end
    tests_run++;
    if (vs_low !== 32) begin
      tests_failed++;
      $display("FAIL vsync_width: low for %0d clk, required 32", vs_low);
    end
    tests_run++;
    if ((fs_cnt !== 3) || (gap_bad !== 0)) begin
      tests_failed++;
      $display("FAIL frame_spacing: %0d pulses with %0d wrong gaps, required 3 pulses 176 clk apart",
               fs_cnt, gap_bad);
    end
    tests_run++;
    if (pol_bad !== 0) begin
      tests_failed++;
      $display("FAIL sync_polarity: %0d cycles not inverted, required 0", pol_bad);
    end
  endtask

  // pix_ce high one clk in two, then held low.
  task automatic test_ce_gating();
    int bad;
    int first_bad;
    int fs_cnt;
    int last_fs;
    int gap_bad;
    int p, ex, ey;
    logic tick;
    bad = 0; first_bad = -1; fs_cnt = 0; last_fs = -1; gap_bad = 0;
    do_reset();
    for (int i = 0; i <= 704; i++) begin
      tick = ((i % 2) == 0);
      pix_ce = tick;
      @(posedge clk);
      #1;
      p  = i / 2;
      ex = p % 16;
      ey = (p / 16) % 11;
      if ((s_x !== 5'(ex)) || (s_y !== 5'(ey)) || (s_ls !== (tick && (ex == 0))) ||
          (s_fs !== (tick && (ex == 0) && (ey == 0))) || (s_active !== ((ex < 8) && (ey < 6)))) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (s_fs === 1'b1) begin
        if ((last_fs >= 0) && (i - last_fs != 352)) gap_bad++;
        last_fs = i;
        fs_cnt++;
      end
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL ce_half_rate: %0d bad cycles (first at cycle %0d), required 0", bad, first_bad);
    end
    tests_run++;
    if ((fs_cnt !== 3) || (gap_bad !== 0)) begin
      tests_failed++;
      $display("FAIL ce_frame_spacing: %0d pulses with %0d wrong gaps, required 3 pulses 352 clk apart",
               fs_cnt, gap_bad);
    end
    pix_ce = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if ({s_x, s_y, s_active, s_hsync, s_vsync, s_ls, s_fs} !== {5'd0, 5'd0, 5'b11100}) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL ce_freeze: %0d cycles moved (x=%0d y=%0d ls=%b fs=%b), required 0",
               bad, s_x, s_y, s_ls, s_fs);
    end
  endtask

  // Reset at (11,7), inside both sync pulses.
  task automatic test_mid_reset();
    do_reset();
    repeat (124) @(posedge clk);
    #1;
    tests_run++;
    if ({s_x, s_y, s_active, s_hsync, s_vsync, p_hsync, p_vsync} !== {5'd11, 5'd7, 5'b00011}) begin
      tests_failed++;
      $display("FAIL pre_reset_pos: x=%0d y=%0d act=%b hs=%b vs=%b phs=%b pvs=%b, required 11 7 0 0 0 1 1",
               s_x, s_y, s_active, s_hsync, s_vsync, p_hsync, p_vsync);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({s_x, s_y, s_active, s_hsync, s_vsync, s_ls, s_fs} !== {5'd0, 5'd0, 5'b01100}) begin
      tests_failed++;
      $display("FAIL mid_reset: x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b, required 0 0 0 1 1 0 0",
               s_x, s_y, s_active, s_hsync, s_vsync, s_ls, s_fs);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({s_x, s_y, s_active, s_ls, s_fs} !== {5'd0, 5'd0, 3'b111}) begin
      tests_failed++;
      $display("FAIL restart: x=%0d y=%0d act=%b ls=%b fs=%b, required 0 0 1 1 1",
               s_x, s_y, s_active, s_ls, s_fs);
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_line_timing();
    test_frame_timing();
    test_ce_gating();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the PONG display: hsync, vsync, active-video flag, pixel coordinates, and line/frame start pulses.
- Sits directly downstream of the power-on reset generator and consumes its reset, presented here as a synchronous active-low rst_n.
- Feeds the ball/paddle renderers and the game-logic frame tick.
- Advances one pixel per clock-enable tick, so one system clock serves any pixel rate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low sync, 1 = active-high)
- CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- pix_ce  in  1  pixel-rate clock enable; counters advance only when high
- hsync  out  1  horizontal sync, level set by SYNC_POL
- vsync  out  1  vertical sync, level set by SYNC_POL
- active  out  1  high while (x,y) is inside the visible area
- x  out  CNT_W  horizontal pixel counter
- y  out  CNT_W  vertical line counter
- line_start  out  1  one-clk pulse when x becomes 0
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Every rising edge where rst_n=0 loads the following, overriding pix_ce:
  - internal h counter = H_TOTAL-1, v counter = V_TOTAL-1
  - x=0, y=0, active=0, line_start=0, frame_start=0
  - hsync and vsync at the deasserted level (~SYNC_POL)
- Rising edge with rst_n=1 and pix_ce=1:
  - h <= (h==H_TOTAL-1) ? 0 : h+1
  - if h wraps: v <= (v==V_TOTAL-1) ? 0 : v+1; otherwise v holds
- Rising edge with rst_n=1 and pix_ce=0: all counters and level outputs hold.
- All outputs are registered and decoded from the next counter values, so they are aligned with x and y:
  - x = h, y = v
  - active = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1 (656..751 by default), else ~SYNC_POL
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= v <= V_ACTIVE+V_FP+V_SYNC-1 (490..491 by default), else ~SYNC_POL
  - vsync changes only on the tick where h wraps to 0.
- Start pulses:
  - line_start = 1 for exactly the one clk cycle after the enabled edge where h becomes 0.
  - frame_start = 1 for exactly the one clk cycle after the enabled edge where h and v both become 0; line_start is also high in that cycle.
  - Both pulses clear on the next clk edge whether or not pix_ce is high.
- Because reset preloads the counters to the last position, the first enabled tick after reset release gives x=0, y=0, active=1, line_start=1, frame_start=1.
- Boundary cases:
  - pix_ce held high continuously: pixel rate = clk rate.
  - pix_ce held low: outputs frozen indefinitely.
  - Reset mid-line or mid-frame: abandons the frame immediately; no pulse is generated on the reset edge.
  - Counters never exceed H_TOTAL-1 or V_TOTAL-1.

Test Plan:
- Reset: rst_n=0 for 3 clk with pix_ce=1 -> x=0, y=0, active=0, hsync=vsync=1, both pulses 0 throughout.
- First tick: release rst_n, pix_ce=1 -> on the first edge x=0, y=0, active=1, line_start=1, frame_start=1; next clk both pulses 0, x=1.
- Line timing with pix_ce always 1:
  - active high for x=0..639, low for 640..799
  - hsync low for exactly 96 clk, x=656..751
  - after x=799 comes x=0 with y incremented and a line_start pulse
- Frame timing:
  - vsync low for exactly 1600 clk (y=490..491)
  - after (799,524) comes (0,0) with frame_start
  - frame_start pulses are spaced exactly 420000 clk apart
- CE gating: pix_ce high 1 clk in every 2 -> each pulse stays 1 clk wide, frame_start spacing is 840000 clk, and x holds when pix_ce=0.
- Reset mid-operation and polarity:
  - assert rst_n=0 at (x=300, y=200) -> reset values next edge; on release, the first tick restarts at (0,0) with frame_start
  - SYNC_POL=1 build -> hsync/vsync waveforms are the exact inversion of the default build
